// File: rtl/openc910_axi_reg_slice128.sv
// Full AXI4 register slice between the C910 core master port and the 128-bit slave model.
// Every channel passes through a 2-entry skid buffer, so all outputs are flop-driven.

module openc910_axi_reg_slice128_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready,
  output logic         dn_valid,
  output logic [W-1:0] dn_data,
  input  logic         dn_ready,
  output logic         busy_d
);

  logic         m_valid_q, m_valid_d;
  logic [W-1:0] m_data_q, m_data_d;
  logic         k_valid_q, k_valid_d;
  logic [W-1:0] k_data_q, k_data_d;
  logic         rdy_q, rdy_d;
  logic         push_s, pop_s;

  // Next-state of main/skid entries; K only fills while M stalls.
  always_comb begin
    push_s    = up_valid & rdy_q;
    pop_s     = m_valid_q & dn_ready;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    k_valid_d = k_valid_q;
    k_data_d  = k_data_q;
    if (pop_s) begin
      if (k_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = k_data_q;
        k_valid_d = 1'b0;
      end else if (push_s) begin
        m_valid_d = 1'b1;
        m_data_d  = up_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (push_s) begin
      if (m_valid_q) begin
        k_valid_d = 1'b1;
        k_data_d  = up_data;
      end else begin
        m_valid_d = 1'b1;
        m_data_d  = up_data;
      end
    end else begin
      m_valid_d = m_valid_q;
    end
    rdy_d  = ~k_valid_d;
    busy_d = m_valid_d | k_valid_d;
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      k_valid_q <= 1'b0;
      k_data_q  <= '0;
      rdy_q     <= 1'b1;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      k_valid_q <= k_valid_d;
      k_data_q  <= k_data_d;
      rdy_q     <= rdy_d;
    end
  end

  assign up_ready = rdy_q;
  assign dn_valid = m_valid_q;
  assign dn_data  = m_data_q;

endmodule

module openc910_axi_reg_slice128 #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    pll_core_cpuclk,
  input  logic                    pad_cpu_rst_b,
  // AW from core
  input  logic [ADDR_WIDTH-1:0]   awaddr_m,
  input  logic [1:0]              awburst_m,
  input  logic [3:0]              awcache_m,
  input  logic [ID_WIDTH-1:0]     awid_m,
  input  logic [7:0]              awlen_m,
  input  logic [2:0]              awprot_m,
  input  logic [2:0]              awsize_m,
  input  logic                    awvalid_m,
  output logic                    awready_m,
  input  logic [DATA_WIDTH-1:0]   wdata_m,
  input  logic [DATA_WIDTH/8-1:0] wstrb_m,
  input  logic [ID_WIDTH-1:0]     wid_m,
  input  logic                    wlast_m,
  input  logic                    wvalid_m,
  output logic                    wready_m,
  input  logic [ADDR_WIDTH-1:0]   araddr_m,
  input  logic [1:0]              arburst_m,
  input  logic [3:0]              arcache_m,
  input  logic [ID_WIDTH-1:0]     arid_m,
  input  logic [7:0]              arlen_m,
  input  logic [2:0]              arprot_m,
  input  logic [2:0]              arsize_m,
  input  logic                    arvalid_m,
  output logic                    arready_m,
  output logic [ID_WIDTH-1:0]     bid_m,
  output logic [1:0]              bresp_m,
  output logic                    bvalid_m,
  input  logic                    bready_m,
  output logic [DATA_WIDTH-1:0]   rdata_m,
  output logic [ID_WIDTH-1:0]     rid_m,
  output logic                    rlast_m,
  output logic [1:0]              rresp_m,
  output logic                    rvalid_m,
  input  logic                    rready_m,
  // Slave side
  output logic [ADDR_WIDTH-1:0]   awaddr_s,
  output logic [1:0]              awburst_s,
  output logic [3:0]              awcache_s,
  output logic [ID_WIDTH-1:0]     awid_s,
  output logic [7:0]              awlen_s,
  output logic [2:0]              awprot_s,
  output logic [2:0]              awsize_s,
  output logic                    awvalid_s,
  input  logic                    awready_s,
  output logic [DATA_WIDTH-1:0]   wdata_s,
  output logic [DATA_WIDTH/8-1:0] wstrb_s,
  output logic [ID_WIDTH-1:0]     wid_s,
  output logic                    wlast_s,
  output logic                    wvalid_s,
  input  logic                    wready_s,
  output logic [ADDR_WIDTH-1:0]   araddr_s,
  output logic [1:0]              arburst_s,
  output logic [3:0]              arcache_s,
  output logic [ID_WIDTH-1:0]     arid_s,
  output logic [7:0]              arlen_s,
  output logic [2:0]              arprot_s,
  output logic [2:0]              arsize_s,
  output logic                    arvalid_s,
  input  logic                    arready_s,
  input  logic [ID_WIDTH-1:0]     bid_s,
  input  logic [1:0]              bresp_s,
  input  logic                    bvalid_s,
  output logic                    bready_s,
  input  logic [DATA_WIDTH-1:0]   rdata_s,
  input  logic [ID_WIDTH-1:0]     rid_s,
  input  logic                    rlast_s,
  input  logic [1:0]              rresp_s,
  input  logic                    rvalid_s,
  output logic                    rready_s,
  output logic                    idle_o
);

  localparam int AX_W = ADDR_WIDTH + 2 + 4 + ID_WIDTH + 8 + 3 + 3;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH/8 + ID_WIDTH + 1;
  localparam int B_W  = ID_WIDTH + 2;
  localparam int R_W  = DATA_WIDTH + ID_WIDTH + 1 + 2;

  logic [AX_W-1:0] aw_up_s, aw_dn_s, ar_up_s, ar_dn_s;
  logic [W_W-1:0]  w_up_s, w_dn_s;
  logic [B_W-1:0]  b_up_s, b_dn_s;
  logic [R_W-1:0]  r_up_s, r_dn_s;
  logic            aw_busy_s, w_busy_s, ar_busy_s, b_busy_s, r_busy_s;
  logic            idle_q, idle_d;

  assign aw_up_s = {awaddr_m, awburst_m, awcache_m, awid_m, awlen_m, awprot_m, awsize_m};
  assign {awaddr_s, awburst_s, awcache_s, awid_s, awlen_s, awprot_s, awsize_s} = aw_dn_s;
  assign ar_up_s = {araddr_m, arburst_m, arcache_m, arid_m, arlen_m, arprot_m, arsize_m};
  assign {araddr_s, arburst_s, arcache_s, arid_s, arlen_s, arprot_s, arsize_s} = ar_dn_s;
  assign w_up_s  = {wdata_m, wstrb_m, wid_m, wlast_m};
  assign {wdata_s, wstrb_s, wid_s, wlast_s} = w_dn_s;
  assign b_up_s  = {bid_s, bresp_s};
  assign {bid_m, bresp_m} = b_dn_s;
  assign r_up_s  = {rdata_s, rid_s, rlast_s, rresp_s};
  assign {rdata_m, rid_m, rlast_m, rresp_m} = r_dn_s;

  openc910_axi_reg_slice128_skid #(.W(AX_W)) u_aw (
    .clk(pll_core_cpuclk), .rst_n(pad_cpu_rst_b),
    .up_valid(awvalid_m), .up_data(aw_up_s), .up_ready(awready_m),
    .dn_valid(awvalid_s), .dn_data(aw_dn_s), .dn_ready(awready_s), .busy_d(aw_busy_s));

  openc910_axi_reg_slice128_skid #(.W(W_W)) u_w (
    .clk(pll_core_cpuclk), .rst_n(pad_cpu_rst_b),
    .up_valid(wvalid_m), .up_data(w_up_s), .up_ready(wready_m),
    .dn_valid(wvalid_s), .dn_data(w_dn_s), .dn_ready(wready_s), .busy_d(w_busy_s));

  openc910_axi_reg_slice128_skid #(.W(AX_W)) u_ar (
    .clk(pll_core_cpuclk), .rst_n(pad_cpu_rst_b),
    .up_valid(arvalid_m), .up_data(ar_up_s), .up_ready(arready_m),
    .dn_valid(arvalid_s), .dn_data(ar_dn_s), .dn_ready(arready_s), .busy_d(ar_busy_s));

  openc910_axi_reg_slice128_skid #(.W(B_W)) u_b (
    .clk(pll_core_cpuclk), .rst_n(pad_cpu_rst_b),
    .up_valid(bvalid_s), .up_data(b_up_s), .up_ready(bready_s),
    .dn_valid(bvalid_m), .dn_data(b_dn_s), .dn_ready(bready_m), .busy_d(b_busy_s));

  openc910_axi_reg_slice128_skid #(.W(R_W)) u_r (
    .clk(pll_core_cpuclk), .rst_n(pad_cpu_rst_b),
    .up_valid(rvalid_s), .up_data(r_up_s), .up_ready(rready_s),
    .dn_valid(rvalid_m), .dn_data(r_dn_s), .dn_ready(rready_m), .busy_d(r_busy_s));

  // Idle reflects next buffer occupancy so it is exact right after each edge.
  always_comb begin
    idle_d = ~(aw_busy_s | w_busy_s | ar_busy_s | b_busy_s | r_busy_s);
  end

  // Idle flag register.
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      idle_q <= 1'b1;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign idle_o = idle_q;

endmodule

// File: tb/tb_openc910_axi_reg_slice128.sv
// Directed self-checking bench for the five-channel AXI register slice.
module tb_openc910_axi_reg_slice128;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [39:0]  awaddr_m, araddr_m, awaddr_s, araddr_s;
  logic [1:0]   awburst_m, arburst_m, awburst_s, arburst_s;
  logic [3:0]   awcache_m, arcache_m, awcache_s, arcache_s;
  logic [7:0]   awid_m, arid_m, awid_s, arid_s, awlen_m, arlen_m, awlen_s, arlen_s;
  logic [2:0]   awprot_m, arprot_m, awprot_s, arprot_s, awsize_m, arsize_m, awsize_s, arsize_s;
  logic         awvalid_m, awready_m, arvalid_m, arready_m, awvalid_s, awready_s, arvalid_s, arready_s;
  logic [127:0] wdata_m, wdata_s, rdata_m, rdata_s;
  logic [15:0]  wstrb_m, wstrb_s;
  logic [7:0]   wid_m, wid_s, bid_m, bid_s, rid_m, rid_s;
  logic         wlast_m, wlast_s, wvalid_m, wready_m, wvalid_s, wready_s;
  logic [1:0]   bresp_m, bresp_s, rresp_m, rresp_s;
  logic         bvalid_m, bready_m, bvalid_s, bready_s;
  logic         rlast_m, rlast_s, rvalid_m, rready_m, rvalid_s, rready_s;
  logic         idle_o;

  int n_checks = 0;
  int n_fail   = 0;

  openc910_axi_reg_slice128 dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_n),
    .awaddr_m(awaddr_m), .awburst_m(awburst_m), .awcache_m(awcache_m), .awid_m(awid_m),
    .awlen_m(awlen_m), .awprot_m(awprot_m), .awsize_m(awsize_m), .awvalid_m(awvalid_m),
    .awready_m(awready_m),
    .wdata_m(wdata_m), .wstrb_m(wstrb_m), .wid_m(wid_m), .wlast_m(wlast_m),
    .wvalid_m(wvalid_m), .wready_m(wready_m),
    .araddr_m(araddr_m), .arburst_m(arburst_m), .arcache_m(arcache_m), .arid_m(arid_m),
    .arlen_m(arlen_m), .arprot_m(arprot_m), .arsize_m(arsize_m), .arvalid_m(arvalid_m),
    .arready_m(arready_m),
    .bid_m(bid_m), .bresp_m(bresp_m), .bvalid_m(bvalid_m), .bready_m(bready_m),
    .rdata_m(rdata_m), .rid_m(rid_m), .rlast_m(rlast_m), .rresp_m(rresp_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m),
    .awaddr_s(awaddr_s), .awburst_s(awburst_s), .awcache_s(awcache_s), .awid_s(awid_s),
    .awlen_s(awlen_s), .awprot_s(awprot_s), .awsize_s(awsize_s), .awvalid_s(awvalid_s),
    .awready_s(awready_s),
    .wdata_s(wdata_s), .wstrb_s(wstrb_s), .wid_s(wid_s), .wlast_s(wlast_s),
    .wvalid_s(wvalid_s), .wready_s(wready_s),
    .araddr_s(araddr_s), .arburst_s(arburst_s), .arcache_s(arcache_s), .arid_s(arid_s),
    .arlen_s(arlen_s), .arprot_s(arprot_s), .arsize_s(arsize_s), .arvalid_s(arvalid_s),
    .arready_s(arready_s),
    .bid_s(bid_s), .bresp_s(bresp_s), .bvalid_s(bvalid_s), .bready_s(bready_s),
    .rdata_s(rdata_s), .rid_s(rid_s), .rlast_s(rlast_s), .rresp_s(rresp_s),
    .rvalid_s(rvalid_s), .rready_s(rready_s),
    .idle_o(idle_o)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, recv, occ;
    logic up, dn;

    {awaddr_m, awburst_m, awcache_m, awid_m, awlen_m, awprot_m, awsize_m, awvalid_m} = '0;
    {araddr_m, arburst_m, arcache_m, arid_m, arlen_m, arprot_m, arsize_m, arvalid_m} = '0;
    {wdata_m, wstrb_m, wid_m, wlast_m, wvalid_m} = '0;
    {bid_s, bresp_s, bvalid_s, rdata_s, rid_s, rlast_s, rresp_s, rvalid_s} = '0;
    awready_s = 1'b1; wready_s = 1'b1; arready_s = 1'b1; bready_m = 1'b1; rready_m = 1'b1;

    // 1. reset held 5 cycles
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_awvalid_s", 160'(awvalid_s), 160'(0));
    check("rst_rvalid_m", 160'(rvalid_m), 160'(0));
    rst_n = 1'b1;
    tick();
    check("rst_valids", 160'({awvalid_s, wvalid_s, arvalid_s, bvalid_m, rvalid_m}), 160'(0));
    check("rst_readies", 160'({awready_m, wready_m, arready_m, bready_s, rready_s}), 160'(5'h1f));
    check("rst_idle", 160'(idle_o), 160'(1));
    check("rst_araddr_s", 160'(araddr_s), 160'(0));

    araddr_m = 40'h00_8000_0000; arid_m = 8'd3; arlen_m = 8'd0; arvalid_m = 1'b1;
    tick();
    arvalid_m = 1'b0;
    check("ar_valid_s", 160'(arvalid_s), 160'(1));
    check("ar_addr_s", 160'(araddr_s), 160'(40'h00_8000_0000));
    check("ar_id_s", 160'(arid_s), 160'(8'd3));
    check("ar_len_s", 160'(arlen_s), 160'(8'd0));
    check("ar_idle", 160'(idle_o), 160'(0));
    tick();
    check("ar_drained", 160'(arvalid_s), 160'(0));
    check("ar_idle_back", 160'(idle_o), 160'(1));

    // 2. 16-beat W stream, no backpressure
    wready_s = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wdata_m = 128'(i); wstrb_m = 16'hffff; wid_m = 8'h21; wlast_m = (i == 15); wvalid_m = 1'b1;
      check("w_ready_m", 160'(wready_m), 160'(1));
      tick();
      check("w_valid_s", 160'(wvalid_s), 160'(1));
      check("w_data_s", 160'(wdata_s), 160'(i));
      check("w_last_s", 160'(wlast_s), 160'(i == 15));
    end
    wvalid_m = 1'b0; wlast_m = 1'b0;
    check("w_strb_s", 160'(wstrb_s), 160'(16'hffff));
    tick();
    check("w_end", 160'(wvalid_s), 160'(0));

    // 3. AW backpressure for 4 cycles
    awready_s = 1'b0;
    awaddr_m = 40'h1000; awid_m = 8'd1; awvalid_m = 1'b1;
    tick();
    check("aw_a_valid", 160'(awvalid_s), 160'(1));
    check("aw_rdy_after1", 160'(awready_m), 160'(1));
    awaddr_m = 40'h2000; awid_m = 8'd2;
    tick();
    awvalid_m = 1'b0;
    check("aw_rdy_after2", 160'(awready_m), 160'(0));
    check("aw_hold1", 160'(awaddr_s), 160'(40'h1000));
    tick();
    tick();
    check("aw_hold2", 160'(awaddr_s), 160'(40'h1000));
    check("aw_hold_valid", 160'(awvalid_s), 160'(1));
    check("aw_full_idle", 160'(idle_o), 160'(0));
    awready_s = 1'b1;
    tick();
    check("aw_drain_b", 160'(awaddr_s), 160'(40'h2000));
    check("aw_drain_id", 160'(awid_s), 160'(8'd2));
    check("aw_rdy_back", 160'(awready_m), 160'(1));
    tick();
    check("aw_drained", 160'(awvalid_s), 160'(0));

    // B single response
    bid_s = 8'd7; bresp_s = 2'd2; bvalid_s = 1'b1; bready_m = 1'b1;
    tick();
    bvalid_s = 1'b0;
    check("b_valid_m", 160'(bvalid_m), 160'(1));
    check("b_id_resp", 160'({bid_m, bresp_m}), 160'({8'd7, 2'd2}));
    tick();
    check("b_drained", 160'(bvalid_m), 160'(0));

    // 4. R burst of 8 with rready_m toggling 1010
    sent = 0; recv = 0; occ = 0;
    rid_s = 8'd5; rresp_s = 2'd0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      rvalid_s = (sent < 8); rdata_s = 128'(sent); rlast_s = (sent == 7);
      rready_m = ((c % 2) == 0);
      check("r_ready_s", 160'(rready_s), 160'(occ != 2));
      up = rvalid_s & rready_s;
      dn = rvalid_m & rready_m;
      if (dn) begin
        check("r_data_m", 160'(rdata_m), 160'(recv));
        check("r_last_m", 160'(rlast_m), 160'(recv == 7));
        check("r_id_m", 160'(rid_m), 160'(8'd5));
      end
      tick();
      if (up) sent++;
      if (dn) recv++;
      occ = occ + int'(up) - int'(dn);
    end
    rvalid_s = 1'b0; rlast_s = 1'b0; rready_m = 1'b1;
    check("r_count", 160'(recv), 160'(8));
    tick();
    check("r_no_dup", 160'(rvalid_m), 160'(0));

    // 6. async reset with R holding 2 beats and W holding 1
    rready_m = 1'b0; wready_s = 1'b0;
    rvalid_s = 1'b1; rdata_s = 128'haa;
    wvalid_m = 1'b1; wdata_m = 128'hcc;
    tick();
    wvalid_m = 1'b0;
    rdata_s = 128'hbb;
    tick();
    rvalid_s = 1'b0;
    check("f_r_full", 160'({rvalid_m, rready_s}), 160'(2'b10));
    check("f_w_held", 160'({wvalid_s, wdata_s}), 160'({1'b1, 128'hcc}));
    #2 rst_n = 1'b0;
    #1;
    check("f_rst_valids", 160'({rvalid_m, wvalid_s}), 160'(0));
    check("f_rst_payload", 160'(rdata_m | wdata_s), 160'(0));
    check("f_rst_readies", 160'({rready_s, wready_m}), 160'(2'b11));
    check("f_rst_idle", 160'(idle_o), 160'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rready_m = 1'b1; wready_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("f_no_emit", 160'({rvalid_m, wvalid_s, idle_o}), 160'(3'b001));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
